// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared types and constants for the arbitrated register bank
package reg_bank_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam int          DATA_W_DEF = 32;
    localparam logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, first requester at or after ptr wins
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    always_comb begin
        logic found;
        int   idx;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - register bank shared by round-robin requesters, with clear sequencer
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int NUM_REGS = 4,
    parameter int ADDR_W   = 2,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    input  logic                      clr_start,
    output logic                      clr_busy
);

    localparam int PTR_W = $clog2(NUM_REQ);

    state_t              state;
    logic [ADDR_W-1:0]   clr_idx;
    logic [PTR_W-1:0]    rr_ptr;
    logic [DATA_W-1:0]   bank [NUM_REGS];

    logic [NUM_REQ-1:0]  grant;
    logic [PTR_W-1:0]    grant_idx;
    logic                granted;
    logic                g_we;
    logic [ADDR_W-1:0]   g_addr;
    logic [DATA_W-1:0]   g_wdata;
    logic                addr_ok;

    // A clear request wins the cycle it is seen: no grant is issued alongside it.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .enable    ((state == RUN) && !clr_start),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign granted   = |grant;
    assign g_we      = req_we[grant_idx];
    assign g_addr    = req_addr[grant_idx*ADDR_W +: ADDR_W];
    assign g_wdata   = req_wdata[grant_idx*DATA_W +: DATA_W];
    assign addr_ok   = int'(g_addr) < NUM_REGS;
    assign clr_busy  = (state == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= CLEAR;
            clr_idx   <= '0;
            rr_ptr    <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                bank[i] <= '0;
            end
        end else begin
            rsp_valid <= grant;
            rsp_err   <= granted && !addr_ok;
            case (state)
                CLEAR: begin
                    bank[clr_idx] <= '0;
                    if (clr_idx == ADDR_W'(NUM_REGS - 1)) begin
                        state   <= RUN;
                        clr_idx <= '0;
                    end else begin
                        clr_idx <= clr_idx + 1'b1;
                    end
                end
                RUN: begin
                    if (clr_start) begin
                        state <= CLEAR;
                    end else if (granted) begin
                        rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
                        // Reads sample the bank before any write this edge; only one access per cycle anyway.
                        if (g_we) begin
                            if (addr_ok) begin
                                bank[g_addr] <= g_wdata;
                            end
                            rsp_rdata <= '0;
                        end else begin
                            rsp_rdata <= addr_ok ? bank[g_addr] : DATA_W'(ERR_RDATA);
                        end
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - randomized and directed self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

    localparam int NR = 2;
    localparam int NG = 4;
    localparam int AW = 2;
    localparam int DW = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR-1:0]    req_valid, req_ready, req_we, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata;
    logic             rsp_err, clr_start, clr_busy;

    logic [1:0]       e_req_valid, e_req_ready, e_req_we, e_rsp_valid;
    logic [3:0]       e_req_addr;
    logic [63:0]      e_req_wdata;
    logic [31:0]      e_rsp_rdata;
    logic             e_rsp_err, e_clr_start, e_clr_busy;

    always #5 clk = ~clk;

    reg_bank_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .clr_start(clr_start), .clr_busy(clr_busy)
    );

    reg_bank_arbiter #(.NUM_REQ(2), .NUM_REGS(3), .ADDR_W(2), .DATA_W(32)) dut_err (
        .clk(clk), .rst_n(rst_n), .req_valid(e_req_valid), .req_ready(e_req_ready),
        .req_we(e_req_we), .req_addr(e_req_addr), .req_wdata(e_req_wdata),
        .rsp_valid(e_rsp_valid), .rsp_rdata(e_rsp_rdata), .rsp_err(e_rsp_err),
        .clr_start(e_clr_start), .clr_busy(e_clr_busy)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: bank contents, remaining clear cycles, rotation pointer, expected responses.
    logic [DW-1:0] m_bank [NG];
    int            m_clear_left;
    int            m_ptr;
    int            m_last_g;
    logic [NR-1:0] m_rv;
    logic [DW-1:0] m_rdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NG; i++) m_bank[i] = '0;
        m_clear_left = NG;
        m_ptr        = 0;
        m_last_g     = -1;
        m_rv         = '0;
        m_rdata      = '0;
    endtask

    function automatic int exp_grant();
        int idx;
        if (m_clear_left > 0 || clr_start) return -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]         = v;
        req_we[i]            = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // One clock: check outputs at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        int g;
        int a;
        @(negedge clk);
        g = exp_grant();
        chk("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : 32'(1 << g));
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_rdata", rsp_rdata, m_rdata);
        if (m_rv != 0) chk("rsp_err", 32'(rsp_err), 32'd0);
        chk("clr_busy", 32'(clr_busy), 32'(m_clear_left > 0));
        @(posedge clk);
        if (g >= 0) begin
            a    = int'(req_addr[g*AW +: AW]);
            m_rv = NR'(1 << g);
            if (req_we[g]) begin
                m_bank[a] = req_wdata[g*DW +: DW];
                m_rdata   = '0;
            end else begin
                m_rdata = m_bank[a];
            end
            m_ptr = (g + 1) % NR;
        end else begin
            m_rv = '0;
        end
        if (m_clear_left > 0) begin
            m_bank[NG - m_clear_left] = '0;
            m_clear_left--;
        end else if (clr_start) begin
            m_clear_left = NG;
        end
        m_last_g = g;
        #1;
    endtask

    task automatic do_access(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic hit;
        hit = 1'b0;
        set_req(i, 1'b1, we, a, d);
        for (int t = 0; t < 20 && !hit; t++) begin
            cycle();
            hit = (m_last_g == i);
        end
        req_valid[i] = 1'b0;
        chk("access_done", 32'(hit), 32'd1);
    endtask

    task automatic e_access(input logic we, input logic [1:0] a, input logic [31:0] d,
                            input logic err, input logic [31:0] rd);
        e_req_valid = 2'b01;
        e_req_we    = {1'b0, we};
        e_req_addr  = {2'b00, a};
        e_req_wdata = {32'd0, d};
        #1;
        chk("e_req_ready", 32'(e_req_ready), 32'd1);
        cycle();
        chk("e_rsp_valid", 32'(e_rsp_valid), 32'd1);
        chk("e_rsp_err", 32'(e_rsp_err), 32'(err));
        chk("e_rsp_rdata", e_rsp_rdata, rd);
        e_req_valid = 2'b00;
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_clr_busy", 32'(clr_busy), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; clr_start = 1'b0;
        e_req_valid = '0; e_req_we = '0; e_req_addr = '0; e_req_wdata = '0; e_clr_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;

        // Post-reset clear: the 3-register instance leaves CLEAR after 3 cycles, the main one after 4.
        for (int k = 0; k < 5; k++) begin
            chk("e_clr_busy", 32'(e_clr_busy), 32'(k < 3));
            cycle();
        end
        for (int r = 0; r < NG; r++) begin
            do_access(0, 1'b0, AW'(r), '0);
            chk("t1_zero", rsp_rdata, 32'd0);
        end

        e_access(1'b1, 2'd3, 32'hAAAA_5555, 1'b1, 32'h0);
        e_access(1'b0, 2'd3, 32'h0, 1'b1, 32'hDEAD_BEEF);
        for (int r = 0; r < 3; r++) e_access(1'b0, 2'(r), 32'h0, 1'b0, 32'h0);
        e_access(1'b1, 2'd2, 32'h1111_2222, 1'b0, 32'h0);
        e_access(1'b0, 2'd2, 32'h0, 1'b0, 32'h1111_2222);

        do_access(0, 1'b1, 2'd2, 32'h1234_5678);
        chk("t2_wr_rsp", 32'(rsp_valid), 32'd1);
        do_access(0, 1'b0, 2'd2, '0);
        chk("t2_rd_rsp", 32'(rsp_valid), 32'd1);
        chk("t2_rdata", rsp_rdata, 32'h1234_5678);

        set_req(0, 1'b1, 1'b0, 2'd2, '0);
        set_req(1, 1'b1, 1'b0, 2'd1, '0);
        repeat (6) cycle();
        req_valid = '0;
        cycle();

        for (int r = 0; r < NG; r++) do_access(1, 1'b1, AW'(r), 32'hFFFF_FFFF);
        set_req(1, 1'b1, 1'b0, 2'd3, '0);
        clr_start = 1'b1;
        cycle();
        chk("t5_no_grant", 32'(m_last_g == -1), 32'd1);
        clr_start = 1'b0;
        repeat (6) cycle();
        req_valid = '0;
        for (int r = 0; r < NG; r++) begin
            do_access(1, 1'b0, AW'(r), '0);
            chk("t5_zero", rsp_rdata, 32'd0);
        end

        // Reset lands on the edge that would have granted a read: the response must never appear.
        set_req(0, 1'b1, 1'b0, 2'd2, '0);
        @(negedge clk);
        #4;
        rst_n = 1'b0;
        #2;
        check_reset_outputs();
        req_valid = '0;
        model_reset();
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (3) cycle();

        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && ($urandom % 10) < 6)
                    set_req(i, 1'b1, 1'($urandom % 2), AW'($urandom_range(0, NG - 1)), $urandom);
            end
            clr_start = (($urandom % 40) == 0);
            cycle();
            clr_start = 1'b0;
            if (m_last_g >= 0) req_valid[m_last_g] = 1'b0;
        end
        req_valid = '0;
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
